// File: rtl/e203_exu_decq_pkg.sv
// Shared constants and the predecode record type for the EXU decode queue.
package e203_exu_decq_pkg;

  localparam int INSTR_SIZE  = 32;
  localparam int RFIDX_WIDTH = 5;

  localparam logic [1:0] BJP_NONE = 2'b00;
  localparam logic [1:0] BJP_JAL  = 2'b01;
  localparam logic [1:0] BJP_JALR = 2'b10;
  localparam logic [1:0] BJP_BXX  = 2'b11;

  typedef struct packed {
    logic                   rv32;
    logic [1:0]             bjp;
    logic [RFIDX_WIDTH-1:0] rs1idx;
    logic [RFIDX_WIDTH-1:0] rs2idx;
    logic [RFIDX_WIDTH-1:0] rdidx;
    logic                   ilegl;
  } predec_t;

endpackage

// File: rtl/e203_exu_predec.sv
// Combinational predecode of a fetched instruction: length, branch/jump class,
// register indices and an early illegal-encoding flag.
module e203_exu_predec
  import e203_exu_decq_pkg::*;
#(
  parameter int RVC_EN    = 1,
  parameter int MULDIV_EN = 1
) (
  input  logic [INSTR_SIZE-1:0]  i_instr,
  output logic                   o_rv32,
  output logic [1:0]             o_bjp,
  output logic [RFIDX_WIDTH-1:0] o_rs1idx,
  output logic [RFIDX_WIDTH-1:0] o_rs2idx,
  output logic [RFIDX_WIDTH-1:0] o_rdidx,
  output logic                   o_ilegl
);

  localparam logic RVC_ON    = (RVC_EN != 0);
  localparam logic MULDIV_ON = (MULDIV_EN != 0);

  logic       w_low11;
  logic       w_b42_all1;
  logic [6:0] w_opcode;
  logic [6:0] w_func7;
  logic [2:0] w_f3c;
  logic       w_c_j;
  logic       w_c_jr;
  logic       w_c_bxx;

  assign w_low11    = (i_instr[1:0] == 2'b11);
  assign w_b42_all1 = (i_instr[4:2] == 3'b111);
  assign w_opcode   = i_instr[6:0];
  assign w_func7    = i_instr[31:25];
  assign w_f3c      = i_instr[15:13];

  assign o_rv32   = w_low11 & ~w_b42_all1;
  assign o_rs1idx = o_rv32 ? i_instr[19:15] : i_instr[11:7];
  assign o_rs2idx = o_rv32 ? i_instr[24:20] : i_instr[6:2];
  assign o_rdidx  = i_instr[11:7];

  // Compressed jumps/branches only classify when 16-bit encodings are legal.
  assign w_c_j   = RVC_ON & (i_instr[1:0] == 2'b01) & ((w_f3c == 3'b001) | (w_f3c == 3'b101));
  assign w_c_jr  = RVC_ON & (i_instr[1:0] == 2'b10) & (w_f3c == 3'b100)
                   & (i_instr[6:2] == 5'd0) & (i_instr[11:7] != 5'd0);
  assign w_c_bxx = RVC_ON & (i_instr[1:0] == 2'b01) & ((w_f3c == 3'b110) | (w_f3c == 3'b111));

  always_comb begin
    o_bjp = BJP_NONE;
    if (o_rv32) begin
      if (w_opcode == 7'b1101111)      o_bjp = BJP_JAL;
      else if (w_opcode == 7'b1100111) o_bjp = BJP_JALR;
      else if (w_opcode == 7'b1100011) o_bjp = BJP_BXX;
    end else begin
      if (w_c_j)        o_bjp = BJP_JAL;
      else if (w_c_jr)  o_bjp = BJP_JALR;
      else if (w_c_bxx) o_bjp = BJP_BXX;
    end
  end

  assign o_ilegl = (w_low11 & w_b42_all1)
                 | (~o_rv32 & (~RVC_ON | (i_instr[15:0] == 16'h0000)))
                 | (~MULDIV_ON & (w_opcode == 7'b0110011) & (w_func7 == 7'b0000001));

endmodule

// File: rtl/e203_exu_decq.sv
// Instruction queue between IFU and EXU decode; entries are predecoded on
// enqueue and presented from the read pointer.
module e203_exu_decq
  import e203_exu_decq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_SIZE   = 32,
  parameter int RVC_EN    = 1,
  parameter int MULDIV_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [INSTR_SIZE-1:0]      i_instr,
  input  logic [PC_SIZE-1:0]         i_pc,
  input  logic                       i_prdt_taken,
  input  logic                       i_misalgn,
  input  logic                       i_buserr,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [INSTR_SIZE-1:0]      o_instr,
  output logic [PC_SIZE-1:0]         o_pc,
  output logic                       o_prdt_taken,
  output logic                       o_misalgn,
  output logic                       o_buserr,
  output logic                       o_rv32,
  output logic [1:0]                 o_bjp,
  output logic [RFIDX_WIDTH-1:0]     o_rs1idx,
  output logic [RFIDX_WIDTH-1:0]     o_rs2idx,
  output logic [RFIDX_WIDTH-1:0]     o_rdidx,
  output logic                       o_ilegl,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [INSTR_SIZE-1:0] r_instr [DEPTH];
  logic [PC_SIZE-1:0]    r_pc    [DEPTH];
  logic [2:0]            r_flags [DEPTH];
  predec_t               r_dec   [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  logic    w_push;
  logic    w_pop;
  logic    w_exc;
  predec_t w_dec;
  predec_t w_dec_store;

  e203_exu_predec #(
    .RVC_EN    (RVC_EN),
    .MULDIV_EN (MULDIV_EN)
  ) u_predec (
    .i_instr  (i_instr),
    .o_rv32   (w_dec.rv32),
    .o_bjp    (w_dec.bjp),
    .o_rs1idx (w_dec.rs1idx),
    .o_rs2idx (w_dec.rs2idx),
    .o_rdidx  (w_dec.rdidx),
    .o_ilegl  (w_dec.ilegl)
  );

  // A fetch exception outranks whatever the encoding looked like.
  assign w_exc = i_misalgn | i_buserr;
  always_comb begin
    w_dec_store = w_dec;
    if (w_exc) begin
      w_dec_store.bjp   = BJP_NONE;
      w_dec_store.ilegl = 1'b0;
    end
  end

  assign i_ready = (r_cnt != CW'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign w_push  = i_valid & i_ready;
  assign w_pop   = o_valid & o_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
        r_flags[i] <= '0;
        r_dec[i]   <= '0;
      end
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wptr] <= i_instr;
        r_pc[r_wptr]    <= i_pc;
        r_flags[r_wptr] <= {i_prdt_taken, i_misalgn, i_buserr};
        r_dec[r_wptr]   <= w_dec_store;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_instr      = r_instr[r_rptr];
  assign o_pc         = r_pc[r_rptr];
  assign o_prdt_taken = r_flags[r_rptr][2];
  assign o_misalgn    = r_flags[r_rptr][1];
  assign o_buserr     = r_flags[r_rptr][0];
  assign o_rv32       = r_dec[r_rptr].rv32;
  assign o_bjp        = r_dec[r_rptr].bjp;
  assign o_rs1idx     = r_dec[r_rptr].rs1idx;
  assign o_rs2idx     = r_dec[r_rptr].rs2idx;
  assign o_rdidx      = r_dec[r_rptr].rdidx;
  assign o_ilegl      = r_dec[r_rptr].ilegl;
  assign o_cnt        = r_cnt;

endmodule

// File: tb/tb_e203_exu_decq.sv
// Directed bench: default queue plus RVC-disabled and MULDIV-disabled variants
// sharing one input stream.
module tb_e203_exu_decq;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        i_valid;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_prdt_taken;
  logic        i_misalgn;
  logic        i_buserr;
  logic        o_ready;

  logic        a_iready, a_valid, a_prdt, a_misalgn, a_buserr, a_rv32, a_ilegl;
  logic [31:0] a_instr, a_pc;
  logic [1:0]  a_bjp;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [2:0]  a_cnt;

  logic        b_iready, b_valid, b_prdt, b_misalgn, b_buserr, b_rv32, b_ilegl;
  logic [31:0] b_instr, b_pc;
  logic [1:0]  b_bjp;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [2:0]  b_cnt;

  logic        c_iready, c_valid, c_prdt, c_misalgn, c_buserr, c_rv32, c_ilegl;
  logic [31:0] c_instr, c_pc;
  logic [1:0]  c_bjp;
  logic [4:0]  c_rs1, c_rs2, c_rd;
  logic [2:0]  c_cnt;

  int total;
  int bad;

  e203_exu_decq u_main (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_ready(a_iready),
    .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .o_valid(a_valid), .o_ready(o_ready), .o_instr(a_instr),
    .o_pc(a_pc), .o_prdt_taken(a_prdt), .o_misalgn(a_misalgn), .o_buserr(a_buserr),
    .o_rv32(a_rv32), .o_bjp(a_bjp), .o_rs1idx(a_rs1), .o_rs2idx(a_rs2), .o_rdidx(a_rd),
    .o_ilegl(a_ilegl), .o_cnt(a_cnt)
  );

  e203_exu_decq #(.RVC_EN(0)) u_norvc (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_ready(b_iready),
    .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .o_valid(b_valid), .o_ready(o_ready), .o_instr(b_instr),
    .o_pc(b_pc), .o_prdt_taken(b_prdt), .o_misalgn(b_misalgn), .o_buserr(b_buserr),
    .o_rv32(b_rv32), .o_bjp(b_bjp), .o_rs1idx(b_rs1), .o_rs2idx(b_rs2), .o_rdidx(b_rd),
    .o_ilegl(b_ilegl), .o_cnt(b_cnt)
  );

  e203_exu_decq #(.MULDIV_EN(0)) u_nomd (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(i_valid), .i_ready(c_iready),
    .i_instr(i_instr), .i_pc(i_pc), .i_prdt_taken(i_prdt_taken), .i_misalgn(i_misalgn),
    .i_buserr(i_buserr), .o_valid(c_valid), .o_ready(o_ready), .o_instr(c_instr),
    .o_pc(c_pc), .o_prdt_taken(c_prdt), .o_misalgn(c_misalgn), .o_buserr(c_buserr),
    .o_rv32(c_rv32), .o_bjp(c_bjp), .o_rs1idx(c_rs1), .o_rs2idx(c_rs2), .o_rdidx(c_rd),
    .o_ilegl(c_ilegl), .o_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; i_valid = 0; i_instr = 0; i_pc = 0;
    i_prdt_taken = 0; i_misalgn = 0; i_buserr = 0; o_ready = 0;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc, input logic be);
    i_valid = 1; i_instr = instr; i_pc = pc; i_buserr = be;
    tick();
    i_valid = 0; i_buserr = 0;
  endtask

  task automatic pop_one();
    o_ready = 1;
    tick();
    o_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL reset_iready got=%b exp=1", a_iready); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_bjp !== 2'b00) begin bad++; $display("FAIL reset_bjp got=%b exp=00", a_bjp); end
    total++; if ({a_pc, a_instr} !== 64'd0) begin bad++; $display("FAIL reset_payload got=%h/%h exp=0", a_pc, a_instr); end
    $display("reset: valid=%b ready=%b cnt=%0d", a_valid, a_iready, a_cnt);
  endtask

  task automatic test_jal();
    push_one(32'h008000EF, 32'h80, 1'b0);
    total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL jal_valid got=%b exp=1", a_valid); end
    total++; if (a_rv32 !== 1'b1) begin bad++; $display("FAIL jal_rv32 got=%b exp=1", a_rv32); end
    total++; if (a_bjp !== 2'b01) begin bad++; $display("FAIL jal_bjp got=%b exp=01", a_bjp); end
    total++; if (a_rd !== 5'd1) begin bad++; $display("FAIL jal_rd got=%0d exp=1", a_rd); end
    total++; if (a_rs2 !== 5'd8) begin bad++; $display("FAIL jal_rs2 got=%0d exp=8", a_rs2); end
    total++; if (a_pc !== 32'h80) begin bad++; $display("FAIL jal_pc got=%h exp=80", a_pc); end
    total++; if (a_cnt !== 3'd1) begin bad++; $display("FAIL jal_cnt got=%0d exp=1", a_cnt); end
    $display("jal: pc=%h bjp=%b rd=%0d", a_pc, a_bjp, a_rd);
    pop_one();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL jal_popped got=%b exp=0", a_valid); end
  endtask

  task automatic test_rvc();
    push_one(32'h0000A001, 32'h90, 1'b0);
    total++; if (a_rv32 !== 1'b0) begin bad++; $display("FAIL cj_rv32 got=%b exp=0", a_rv32); end
    total++; if (a_bjp !== 2'b01) begin bad++; $display("FAIL cj_bjp got=%b exp=01", a_bjp); end
    total++; if (a_ilegl !== 1'b0) begin bad++; $display("FAIL cj_ilegl got=%b exp=0", a_ilegl); end
    total++; if (b_ilegl !== 1'b1) begin bad++; $display("FAIL cj_norvc_ilegl got=%b exp=1", b_ilegl); end
    $display("c.j: rv32=%b bjp=%b ilegl=%b norvc_ilegl=%b", a_rv32, a_bjp, a_ilegl, b_ilegl);
    pop_one();
    push_one(32'h00008082, 32'h94, 1'b0);
    total++; if (a_bjp !== 2'b10) begin bad++; $display("FAIL cjr_bjp got=%b exp=10", a_bjp); end
    total++; if (a_rs1 !== 5'd1) begin bad++; $display("FAIL cjr_rs1 got=%0d exp=1", a_rs1); end
    $display("c.jr: bjp=%b rs1=%0d", a_bjp, a_rs1);
    pop_one();
  endtask

  task automatic test_muldiv();
    push_one(32'h022081B3, 32'hA0, 1'b0);
    total++; if (c_ilegl !== 1'b1) begin bad++; $display("FAIL mul_nomd_ilegl got=%b exp=1", c_ilegl); end
    total++; if (a_ilegl !== 1'b0) begin bad++; $display("FAIL mul_main_ilegl got=%b exp=0", a_ilegl); end
    total++; if ({c_rs1, c_rs2, c_rd} !== {5'd1, 5'd2, 5'd3}) begin
      bad++; $display("FAIL mul_idx got=%0d/%0d/%0d exp=1/2/3", c_rs1, c_rs2, c_rd);
    end
    $display("mul: nomd_ilegl=%b rs1=%0d rs2=%0d rd=%0d", c_ilegl, c_rs1, c_rs2, c_rd);
    pop_one();
    push_one(32'h022081B3, 32'hA4, 1'b1);
    total++; if (c_ilegl !== 1'b0) begin bad++; $display("FAIL mul_buserr_ilegl got=%b exp=0", c_ilegl); end
    total++; if (c_buserr !== 1'b1) begin bad++; $display("FAIL mul_buserr_flag got=%b exp=1", c_buserr); end
    $display("mul+buserr: ilegl=%b buserr=%b", c_ilegl, c_buserr);
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] pc;
    for (int k = 0; k < 4; k++) begin
      push_one(32'h00000013, 32'h100 + 32'(4*k), 1'b0);
      exp_q.push_back(32'h100 + 32'(4*k));
    end
    total++; if (a_cnt !== 3'd4) begin bad++; $display("FAIL full_cnt got=%0d exp=4", a_cnt); end
    total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL full_iready got=%b exp=0", a_iready); end
    // Full queue refuses a push even when the head is popped that cycle.
    i_valid = 1; i_pc = 32'h200; o_ready = 1;
    tick();
    i_valid = 0; o_ready = 0;
    void'(exp_q.pop_front());
    total++; if (a_cnt !== 3'd3) begin bad++; $display("FAIL full_pop_cnt got=%0d exp=3", a_cnt); end
    for (int k = 0; k < 10; k++) begin
      total++; if (a_pc !== exp_q[0]) begin bad++; $display("FAIL wrap_pc%0d got=%h exp=%h", k, a_pc, exp_q[0]); end
      pc = 32'h300 + 32'(4*k);
      i_valid = 1; i_pc = pc; o_ready = 1;
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(pc);
      $display("wrap %0d: head=%h cnt=%0d", k, a_pc, a_cnt);
    end
    i_valid = 0;
    total++; if (a_cnt !== 3'd3) begin bad++; $display("FAIL wrap_cnt got=%0d exp=3", a_cnt); end
    while (exp_q.size() != 0) begin
      total++; if (a_pc !== exp_q[0]) begin bad++; $display("FAIL drain_pc got=%h exp=%h", a_pc, exp_q[0]); end
      tick();
      void'(exp_q.pop_front());
    end
    o_ready = 0;
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", a_valid); end
  endtask

  task automatic test_flush();
    push_one(32'h00000013, 32'h3F0, 1'b0);
    push_one(32'h00000013, 32'h3F4, 1'b0);
    total++; if (a_cnt !== 3'd2) begin bad++; $display("FAIL preflush_cnt got=%0d exp=2", a_cnt); end
    flush = 1; i_valid = 1; i_pc = 32'h400; o_ready = 1;
    tick();
    flush = 0; i_valid = 0; o_ready = 0;
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", a_cnt); end
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", a_valid); end
    tick();
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", a_valid); end
    push_one(32'h00000013, 32'h500, 1'b0);
    total++; if (a_pc !== 32'h500) begin bad++; $display("FAIL postflush_pc got=%h exp=500", a_pc); end
    $display("flush: cnt=%0d head=%h", a_cnt, a_pc);
  endtask

  task automatic test_async_reset();
    push_one(32'h008000EF, 32'h600, 1'b0);
    #2 rst = 1;
    #1;
    total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", a_valid); end
    total++; if (a_pc !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h exp=0", a_pc); end
    total++; if (a_cnt !== 3'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", a_cnt); end
    $display("async reset: valid=%b cnt=%0d", a_valid, a_cnt);
    tick();
    rst = 0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_jal();
    test_rvc();
    test_muldiv();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
